// File: rtl/spectrum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_pkg
//  Purpose  : Shared types and constants for the spectrum band packer.
//             N_BANDS / LEVEL_W sizing, per-band level type, the packed
//             16x4-bit band vector, and the packer state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package spectrum_pkg;

  localparam int N_BANDS = 16;
  localparam int LEVEL_W = 4;

  typedef logic [LEVEL_W-1:0]               level_t;
  typedef logic [N_BANDS-1:0][LEVEL_W-1:0]  band_vec_t;

  typedef enum logic [1:0] {
    S_ACC     = 2'd0,
    S_FLUSH   = 2'd1,
    S_PUBLISH = 2'd2
  } packer_state_e;

endpackage
`default_nettype wire

// File: rtl/band_log_quantizer.sv
`default_nettype none
// ============================================================================
//  Module   : band_log_quantizer
//  Purpose  : Combinational log2 quantizer for one band sum.
//             sum == 0 -> level 0; otherwise level = clamp(msb - LOG_OFFSET + 1,
//             0, 2**LEVEL_W - 1) where msb is the index of the highest set bit.
//  Ports    : i_sum   [SUM_W-1:0]  band sum (unsigned)
//             o_level [LEVEL_W-1:0] quantized level
//  Revision : 1.0 - initial release
// ============================================================================
module band_log_quantizer
  import spectrum_pkg::*;
#(
  parameter int SUM_W      = 20,
  parameter int LOG_OFFSET = 4
) (
  input  logic [SUM_W-1:0] i_sum,
  output level_t           o_level
);

  localparam int MAX_LEVEL = (1 << LEVEL_W) - 1;

  int msb;
  int lvl;

  always_comb begin
    // Ascending scan: the last set bit seen is the most significant one.
    msb = 0;
    for (int i = 0; i < SUM_W; i++) begin
      if (i_sum[i]) msb = i;
    end
    lvl = msb - LOG_OFFSET + 1;

    if (i_sum == '0)            o_level = '0;
    else if (lvl < 0)           o_level = '0;
    else if (lvl > MAX_LEVEL)   o_level = level_t'(MAX_LEVEL);
    else                        o_level = level_t'(lvl);
  end

endmodule
`default_nettype wire

// File: rtl/spectrum_band_packer.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_band_packer
//  Purpose  : Sums a serial stream of FFT magnitude bins into 16 equal bands,
//             log2-quantizes each band to 4 bits and publishes all 16 levels
//             at once per frame together with a one-cycle frame strobe.
//  Ports    : i_clk, i_rst (async, active high)
//             i_bin_valid / o_bin_ready  bin handshake
//             i_bin_mag [15:0]           bin magnitude
//             i_bin_last                 final bin of the frame
//             o_data [15:0][3:0]         published levels, [0] = lowest band
//             o_frame_clk                pulse when o_data updates
//             o_len_err                  pulse with o_frame_clk on an over-long frame
//  Config   : SPECTRUM_PEAK_DECAY_EN - when defined, each published level is
//             max(new, previous - 1) so peaks fall off one step per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module spectrum_band_packer
  import spectrum_pkg::*;
#(
  parameter int N_BINS     = 256,
  parameter int LOG_OFFSET = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bin_valid,
  output logic        o_bin_ready,
  input  logic [15:0] i_bin_mag,
  input  logic        i_bin_last,
  output band_vec_t   o_data,
  output logic        o_frame_clk,
  output logic        o_len_err
);

  localparam int BAND_BINS  = N_BINS / N_BANDS;
  localparam int BAND_W     = $clog2(BAND_BINS);
  localparam int SUM_W      = 16 + BAND_W;
  localparam int BAND_IDX_W = $clog2(N_BANDS);
  // One spare bit so the index can sit at N_BINS once the frame is full.
  localparam int IDX_W      = $clog2(N_BINS) + 1;

  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(N_BINS);
  localparam logic [IDX_W-1:0] BIN_MASK = IDX_W'(BAND_BINS - 1);

  packer_state_e           state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [SUM_W-1:0]        acc_q;
  logic                    done_valid_q;
  logic [BAND_IDX_W-1:0]   done_band_q;
  logic [SUM_W-1:0]        done_sum_q;
  logic                    err_q;
  band_vec_t               shadow_q;
  band_vec_t               data_q;
  logic                    frame_q;
  logic                    len_err_q;

  logic                    accept;
  logic                    in_range;
  logic                    band_end;
  logic                    flush_partial;
  logic [BAND_IDX_W-1:0]   band_cur;
  logic [SUM_W-1:0]        acc_sum;
  logic [SUM_W-1:0]        q_sum;
  logic [BAND_IDX_W-1:0]   q_band;
  logic                    q_write;
  level_t                  q_level;
  band_vec_t               shadow_d;
  band_vec_t               pub_vec_d;

  // Single shared quantizer: completed bands reach it one cycle after their
  // last bin, and the trailing partial band reaches it in S_FLUSH.
  band_log_quantizer #(
    .SUM_W      (SUM_W),
    .LOG_OFFSET (LOG_OFFSET)
  ) u_quant (
    .i_sum   (q_sum),
    .o_level (q_level)
  );

  always_comb begin
    accept   = i_bin_valid && (state_q == S_ACC);
    in_range = (idx_q < IDX_END);
    band_cur = BAND_IDX_W'(idx_q >> BAND_W);
    band_end = ((idx_q & BIN_MASK) == BIN_MASK);
    acc_sum  = acc_q + SUM_W'(i_bin_mag);

    // A completed band pending in S_FLUSH means the last bin closed a band,
    // so there is no partial band left; otherwise quantize the partial sum.
    flush_partial = (state_q == S_FLUSH) && !done_valid_q;
    q_sum         = flush_partial ? acc_q    : done_sum_q;
    q_band        = flush_partial ? band_cur : done_band_q;
    // Past N_BINS every band is already written; the dropped bins leave no partial.
    q_write       = done_valid_q || (flush_partial && in_range);

    shadow_d = shadow_q;
    if (q_write) shadow_d[q_band] = q_level;

`ifdef SPECTRUM_PEAK_DECAY_EN
    pub_vec_d = shadow_d;
    for (int k = 0; k < N_BANDS; k++) begin : g_decay
      level_t dec_lv;
      dec_lv = (data_q[k] == '0) ? '0 : data_q[k] - LEVEL_W'(1);
      pub_vec_d[k] = (shadow_d[k] > dec_lv) ? shadow_d[k] : dec_lv;
    end
`else
    pub_vec_d = shadow_d;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_ACC;
      idx_q        <= '0;
      acc_q        <= '0;
      done_valid_q <= 1'b0;
      done_band_q  <= '0;
      done_sum_q   <= '0;
      err_q        <= 1'b0;
      shadow_q     <= '0;
      data_q       <= '0;
      frame_q      <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      frame_q      <= 1'b0;
      len_err_q    <= 1'b0;
      done_valid_q <= 1'b0;

      unique case (state_q)
        S_ACC: begin
          shadow_q <= shadow_d;
          if (accept) begin
            if (in_range) begin
              idx_q <= idx_q + IDX_W'(1);
              if (band_end) begin
                done_valid_q <= 1'b1;
                done_sum_q   <= acc_sum;
                done_band_q  <= band_cur;
                acc_q        <= '0;
              end else begin
                acc_q <= acc_sum;
              end
            end else begin
              err_q <= 1'b1;
            end
            if (i_bin_last) state_q <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          data_q     <= pub_vec_d;
          frame_q    <= 1'b1;
          len_err_q  <= err_q;
          shadow_q   <= '0;
          acc_q      <= '0;
          done_sum_q <= '0;
          idx_q      <= '0;
          err_q      <= 1'b0;
          state_q    <= S_PUBLISH;
        end

        S_PUBLISH: begin
          state_q <= S_ACC;
        end

        default: begin
          state_q <= S_ACC;
        end
      endcase
    end
  end

  assign o_bin_ready = (state_q == S_ACC);
  assign o_data      = data_q;
  assign o_frame_clk = frame_q;
  assign o_len_err   = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spectrum_band_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spectrum_band_packer
//  Purpose  : Directed self-checking bench for spectrum_band_packer.
//             Expectations follow SPECTRUM_PEAK_DECAY_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spectrum_band_packer;
  import spectrum_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_bin_valid;
  logic        o_bin_ready;
  logic [15:0] i_bin_mag;
  logic        i_bin_last;
  band_vec_t   o_data;
  logic        o_frame_clk;
  logic        o_len_err;

  int errors = 0;
  int checks = 0;
  band_vec_t prev_pub;

  spectrum_band_packer #(
    .N_BINS     (256),
    .LOG_OFFSET (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bin_valid (i_bin_valid),
    .o_bin_ready (o_bin_ready),
    .i_bin_mag   (i_bin_mag),
    .i_bin_last  (i_bin_last),
    .o_data      (o_data),
    .o_frame_clk (o_frame_clk),
    .o_len_err   (o_len_err)
  );

  always #5 clk = ~clk;

  function automatic band_vec_t fill(input logic [3:0] l);
    fill = {16{l}};
  endfunction

  // Expected publish given the freshly quantized levels and the last publish.
  function automatic band_vec_t model_pub(input band_vec_t nv);
    band_vec_t r;
    r = nv;
`ifdef SPECTRUM_PEAK_DECAY_EN
    for (int k = 0; k < 16; k++) begin
      logic [3:0] d;
      d = (prev_pub[k] == 4'd0) ? 4'd0 : prev_pub[k] - 4'd1;
      if (d > nv[k]) r[k] = d;
    end
`endif
    return r;
  endfunction

  // Presents n bins with random idle gaps; bins hot_lo..hot_hi use hot_mag.
  // Returns at the negedge of the cycle after the last bin was accepted.
  task automatic feed_frame(input int n, input logic [15:0] base_mag,
                            input int hot_lo, input int hot_hi, input logic [15:0] hot_mag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        i_bin_valid = 1'b0;
        @(negedge clk);
      end
      i_bin_valid = 1'b1;
      i_bin_mag   = (i >= hot_lo && i <= hot_hi) ? hot_mag : base_mag;
      i_bin_last  = (i == n - 1);
      if (o_bin_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ready_in_frame: %0d bins saw o_bin_ready low, required 0", bad);
    end
  endtask

  // Checks T+1..T+3 after the last bin; junk bins are offered while ready is low.
  task automatic check_publish(input string name, input band_vec_t exp, input logic exp_err);
    checks++;
    if (o_bin_ready !== 1'b0 || o_frame_clk !== 1'b0) begin
      errors++;
      $display("FAIL %s_t1: ready=%b frame_clk=%b, required 0 0", name, o_bin_ready, o_frame_clk);
    end
    i_bin_valid = 1'b1;
    i_bin_mag   = 16'hFFFF;
    i_bin_last  = 1'b1;
    @(negedge clk);
    checks++;
    if (o_bin_ready !== 1'b0 || o_frame_clk !== 1'b1) begin
      errors++;
      $display("FAIL %s_t2: ready=%b frame_clk=%b, required 0 1", name, o_bin_ready, o_frame_clk);
    end
    checks++;
    if (o_data !== exp) begin
      errors++;
      $display("FAIL %s_data: got %h, required %h", name, o_data, exp);
    end
    checks++;
    if (o_len_err !== exp_err) begin
      errors++;
      $display("FAIL %s_len_err: got %b, required %b", name, o_len_err, exp_err);
    end
    i_bin_valid = 1'b0;
    i_bin_last  = 1'b0;
    i_bin_mag   = 16'h0;
    @(negedge clk);
    checks++;
    if (o_bin_ready !== 1'b1 || o_frame_clk !== 1'b0 || o_len_err !== 1'b0 || o_data !== exp) begin
      errors++;
      $display("FAIL %s_t3: ready=%b frame_clk=%b len_err=%b data=%h, required 1 0 0 %h",
               name, o_bin_ready, o_frame_clk, o_len_err, o_data, exp);
    end
    prev_pub = exp;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    i_bin_valid = 1'b0;
    i_bin_mag   = 16'h0;
    i_bin_last  = 1'b0;
    prev_pub    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_data !== '0 || o_frame_clk !== 1'b0 || o_len_err !== 1'b0 || o_bin_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: data=%h frame_clk=%b len_err=%b ready=%b, required 0 0 0 1",
               o_data, o_frame_clk, o_len_err, o_bin_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_data !== '0 || o_bin_ready !== 1'b1 || o_frame_clk !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: data=%h ready=%b frame_clk=%b, required 0 1 0",
               o_data, o_bin_ready, o_frame_clk);
    end
  endtask

  task automatic test_full_frame();
    feed_frame(256, 16'd16, -1, -1, 16'd0);
    check_publish("full_frame", model_pub(fill(4'd5)), 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 20; i++) begin
      i_bin_valid = 1'b1;
      i_bin_mag   = 16'd16;
      i_bin_last  = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (o_data !== '0 || o_bin_ready !== 1'b1 || o_frame_clk !== 1'b0 || o_len_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: data=%h ready=%b frame_clk=%b len_err=%b, required 0 1 0 0",
               o_data, o_bin_ready, o_frame_clk, o_len_err);
    end
    i_bin_valid = 1'b0;
    i_bin_mag   = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    prev_pub = '0;
    @(negedge clk);
  endtask

  task automatic test_single_band();
    band_vec_t e;
    e    = '0;
    e[3] = 4'd15;
    feed_frame(256, 16'd0, 48, 63, 16'hFFFF);
    check_publish("single_band", model_pub(e), 1'b0);
  endtask

  task automatic test_short_frame();
    band_vec_t e;
    e    = '0;
    e[0] = 4'd3;
    e[1] = 4'd3;
    e[2] = 4'd2;
    feed_frame(40, 16'd4, -1, -1, 16'd0);
    check_publish("short_frame", model_pub(e), 1'b0);
  endtask

  task automatic test_band_boundary();
    band_vec_t e;
    e    = '0;
    e[0] = 4'd3;
    e[1] = 4'd3;
    feed_frame(32, 16'd4, -1, -1, 16'd0);
    check_publish("band_boundary", model_pub(e), 1'b0);
  endtask

  task automatic test_long_frame();
    feed_frame(300, 16'd16, -1, -1, 16'd0);
    check_publish("long_frame", model_pub(fill(4'd5)), 1'b1);
  endtask

  task automatic test_one_bin();
    band_vec_t e;
    e    = '0;
    e[0] = 4'd5;
    feed_frame(1, 16'd256, -1, -1, 16'd0);
    check_publish("one_bin", model_pub(e), 1'b0);
  endtask

  task automatic test_peak_decay();
    feed_frame(256, 16'd16, -1, -1, 16'd0);
    check_publish("decay_f1", fill(4'd5), 1'b0);
    feed_frame(1, 16'd0, -1, -1, 16'd0);
`ifdef SPECTRUM_PEAK_DECAY_EN
    check_publish("decay_f2", fill(4'd4), 1'b0);
`else
    check_publish("decay_f2", fill(4'd0), 1'b0);
`endif
    feed_frame(1, 16'd0, -1, -1, 16'd0);
`ifdef SPECTRUM_PEAK_DECAY_EN
    check_publish("decay_f3", fill(4'd3), 1'b0);
`else
    check_publish("decay_f3", fill(4'd0), 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_reset_mid_frame();
    test_single_band();
    test_short_frame();
    test_band_boundary();
    test_long_frame();
    test_one_bin();
    test_peak_decay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
